// File: rtl/fir_output_serializer.sv
// Purpose: buffers 3-sample FIR groups and emits them one lane per transfer, requantized to OUT_W bits (FIR_OUT_SAT_EN selects clamp instead of wrap).
// Latency: first sample is valid the cycle after a group lands in an empty FIFO.
// Backpressure: out_ready stalls the lane counter; in_ready depends only on registered fill level.
module fir_output_serializer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [IN_W-1:0]       y0,
    input  logic signed [IN_W-1:0]       y1,
    input  logic signed [IN_W-1:0]       y2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_W-1:0]      out_data,
    output logic [1:0]                   out_phase,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic signed [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic signed [OUT_W-1:0] Q_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] Q_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic signed [IN_W-1:0] y2;
        logic signed [IN_W-1:0] y1;
        logic signed [IN_W-1:0] y0;
    } grp_t;

    grp_t                   mem [DEPTH];
    grp_t                   head;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [1:0]             phase;
    logic [LW-1:0]          count;
    logic                   ovf_q;
    logic                   push;
    logic                   xfer;
    logic                   pop;
    logic signed [IN_W-1:0] lane;
    logic signed [IN_W:0]   sum;
    logic signed [IN_W:0]   q;
    logic [IN_W-OUT_W+1:0]  q_hi;
    logic                   in_range;
    logic signed [OUT_W-1:0] q_out;

    assign in_ready  = !rst && (count < DEPTH_L);
    assign out_valid = !rst && (count != '0);
    assign push      = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (phase == 2'd2);
    assign head      = mem[rd_ptr];

    always_comb begin
        lane = head.y0;
        case (phase)
            2'd1:    lane = head.y1;
            2'd2:    lane = head.y2;
            default: lane = head.y0;
        endcase
    end

    // Round half up at IN_W+1 bits so the rounding add cannot overflow.
    assign sum      = $signed({lane[IN_W-1], lane}) + RND;
    assign q        = sum >>> SHIFT;
    assign q_hi     = q[IN_W:OUT_W-1];
    assign in_range = (&q_hi) || !(|q_hi);

`ifdef FIR_OUT_SAT_EN
    assign q_out = in_range ? q[OUT_W-1:0] : (q[IN_W] ? Q_MIN : Q_MAX);
`else
    assign q_out = q[OUT_W-1:0];
`endif

    assign out_data  = rst ? '0 : q_out;
    assign out_phase = rst ? 2'd0 : phase;
    assign level     = rst ? '0 : count;
    assign ovf       = rst ? 1'b0 : ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            phase  <= 2'd0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (xfer)
                phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (xfer && !in_range)
                ovf_q <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{y2: y2, y1: y1, y0: y0};
    end

endmodule

// File: tb/tb_fir_output_serializer.sv
// Directed bench for fir_output_serializer: reset, single group, requantize range, full FIFO,
// mid-group stall and reset in mid-operation. Inputs change and outputs are sampled on negedge.
module tb_fir_output_serializer;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] y0, y1, y2;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [1:0]         out_phase;
    logic [2:0]         level;
    logic               ovf;

    int checks = 0;
    int errors = 0;

    fir_output_serializer #(.IN_W(32), .OUT_W(16), .SHIFT(15), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_phase(out_phase), .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_grp(input int a, input int b, input int c);
        y0 = a;
        y1 = b;
        y2 = c;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_grp(0, 0, 0);

        // Reset held 3 cycles
        repeat (3) cyc();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_phase", out_phase, 0);
        rst = 1'b0;
        cyc();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Single group, free-flowing output
        in_valid = 1'b1; out_ready = 1'b1;
        set_grp(32768, 16384, -49152);
        cyc();
        in_valid = 1'b0;
        chk("single_vld0", out_valid, 1);
        chk("single_d0", out_data, 1);
        chk("single_p0", out_phase, 0);
        cyc();
        chk("single_d1", out_data, 1);
        chk("single_p1", out_phase, 1);
        cyc();
        chk("single_d2", out_data, -1);
        chk("single_p2", out_phase, 2);
        cyc();
        chk("single_empty", out_valid, 0);
        chk("single_level", level, 0);
        chk("single_ovf", ovf, 0);

        // Out-of-range samples
        in_valid = 1'b1;
        set_grp(32'h7FFF_FFFF, 32'h8000_0000, 0);
        cyc();
        in_valid = 1'b0;
`ifdef FIR_OUT_SAT_EN
        chk("sat_pos", out_data, 32767);
`else
        chk("wrap_pos", out_data, 0);
`endif
        chk("ovf_before_xfer", ovf, 0);
        cyc();
        chk("ovf_after_xfer", ovf, 1);
`ifdef FIR_OUT_SAT_EN
        chk("sat_neg", out_data, -32768);
`else
        chk("wrap_neg", out_data, 0);
`endif
        cyc();
        chk("sat_lane2", out_data, 0);
        cyc();
        chk("sat_empty", out_valid, 0);
        chk("ovf_sticky", ovf, 1);

        // Fill FIFO with out_ready low; 5th group must be dropped
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int g = 0; g < 5; g++) begin
            set_grp((3*g+1) * 32768, (3*g+2) * 32768, (3*g+3) * 32768);
            cyc();
        end
        in_valid = 1'b0;
        chk("full_level", level, 4);
        chk("full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("drain_data", out_data, i + 1);
            chk("drain_phase", out_phase, i % 3);
            chk("drain_in_ready", in_ready, (i >= 3) ? 1 : 0);
            chk("drain_level", level, 4 - i / 3);
            cyc();
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_level0", level, 0);

        // Stall at phase 1 for 3 cycles
        in_valid = 1'b1;
        set_grp(100 * 32768, 200 * 32768, 300 * 32768);
        cyc();
        in_valid = 1'b0;
        chk("stall_d0", out_data, 100);
        cyc();
        chk("stall_d1", out_data, 200);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_hold_data", out_data, 200);
            chk("stall_hold_phase", out_phase, 1);
            chk("stall_hold_vld", out_valid, 1);
        end
        out_ready = 1'b1;
        cyc();
        chk("stall_resume_d2", out_data, 300);
        chk("stall_resume_p2", out_phase, 2);
        cyc();
        chk("stall_empty", out_valid, 0);

        // Reset while level=2, phase=1
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_grp(1 * 32768, 2 * 32768, 3 * 32768);
        cyc();
        set_grp(4 * 32768, 5 * 32768, 6 * 32768);
        cyc();
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("mid_level", level, 2);
        chk("mid_phase", out_phase, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_after_level", level, 0);
        chk("mid_after_vld", out_valid, 0);
        chk("mid_after_phase", out_phase, 0);
        chk("mid_after_ovf", ovf, 0);
        chk("mid_after_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b1; out_ready = 1'b1;
        set_grp(7 * 32768, 8 * 32768, 9 * 32768);
        cyc();
        in_valid = 1'b0;
        chk("mid_push_d0", out_data, 7);
        chk("mid_push_p0", out_phase, 0);
        cyc();
        chk("mid_push_d1", out_data, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
